// File: rtl/word_gen_dispatch_pkg.sv
// Shared constants for word_gen_dispatch: FSM encodings, default word geometry and a
// constant-width helper.
package word_gen_dispatch_pkg;

    localparam logic [1:0] ST_EMPTY  = 2'd0;
    localparam logic [1:0] ST_LOADED = 2'd1;
    localparam logic [1:0] ST_HALT   = 2'd2;

    localparam int CHAR_BITS_DEF    = 7;
    localparam int WORD_MAX_LEN_DEF = 8;
    localparam int WORD_BITS        = WORD_MAX_LEN_DEF * CHAR_BITS_DEF;

    // Width needed to index n items; never less than 1 bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/word_gen_dispatch_rr_pick.sv
// Round-robin picker: first requester at or after i_ptr, wrapping modulo N.
// Purely combinational; o_gnt is all-zero when nothing requests.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [PW-1:0] o_idx
);

    logic w_found;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!w_found && i_req[(int'(i_ptr) + i) % N]) begin
                w_found                        = 1'b1;
                o_gnt[(int'(i_ptr) + i) % N]   = 1'b1;
                o_idx                          = PW'((int'(i_ptr) + i) % N);
            end
        end
    end

endmodule

// File: rtl/word_gen_dispatch.sv
// Pops words from word_gen into a 1-entry register, hands each to the next non-full core
// round-robin (optional per-core counters: WORD_GEN_DISPATCH_CNT_EN).
// Latency: pop in t, strobe earliest t+1; 1 word/cycle; all-full cores hold the word and stall the pop.
module word_gen_dispatch
    import word_gen_dispatch_pkg::*;
#(
    parameter int NUM_CORES    = 4,
    parameter int CHAR_BITS    = CHAR_BITS_DEF,
    parameter int WORD_MAX_LEN = WORD_MAX_LEN_DEF
) (
    input  logic                                CLK,
    input  logic                                rst_n,
    input  logic                                halt,
    input  logic                                gen_empty,
    output logic                                gen_rd_en,
    input  logic [WORD_MAX_LEN*CHAR_BITS-1:0]   gen_dout,
    input  logic [15:0]                         gen_pkt_id,
    input  logic [15:0]                         gen_word_id,
    input  logic [31:0]                         gen_id,
    input  logic                                gen_end,
    output logic [WORD_MAX_LEN*CHAR_BITS-1:0]   core_dout,
    output logic [15:0]                         core_pkt_id,
    output logic [15:0]                         core_word_id,
    output logic [31:0]                         core_gen_id,
    output logic [NUM_CORES-1:0]                core_wr_en,
    input  logic [NUM_CORES-1:0]                core_full,
`ifdef WORD_GEN_DISPATCH_CNT_EN
    output logic [NUM_CORES*32-1:0]             core_cnt,
`endif
    output logic                                pkt_done,
    output logic [15:0]                         pkt_done_id,
    output logic                                busy
);

    localparam int PW = clog2(NUM_CORES);
    localparam int WB = WORD_MAX_LEN * CHAR_BITS;

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic                 r_end;
    logic [PW-1:0]        r_rr_ptr;
    logic [WB-1:0]        r_dout;
    logic [15:0]          r_pkt_id;
    logic [15:0]          r_word_id;
    logic [31:0]          r_gen_id;
    logic                 r_pkt_done;
    logic [15:0]          r_pkt_done_id;

    logic                 w_valid;
    logic                 w_deliver;
    logic                 w_fetch_ok;
    logic [NUM_CORES-1:0] w_gnt;
    logic [PW-1:0]        w_idx;

    rr_pick #(.N(NUM_CORES), .PW(PW)) u_rr_pick (
        .i_req (~core_full),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx)
    );

    assign w_valid    = (r_state == ST_LOADED);
    assign w_deliver  = w_valid & (|(~core_full));
    assign w_fetch_ok = ~halt & (r_state != ST_HALT);
    // rst_n gate keeps the pop quiet while reset is held even though the FSM sits in ST_EMPTY.
    assign gen_rd_en  = rst_n & w_fetch_ok & ~gen_empty & (~w_valid | w_deliver);
    assign core_wr_en = {NUM_CORES{w_deliver}} & w_gnt;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (gen_rd_en)  w_state_nxt = ST_LOADED;
                else if (halt)  w_state_nxt = ST_HALT;
            end
            ST_LOADED: begin
                if (w_deliver && !gen_rd_en) w_state_nxt = halt ? ST_HALT : ST_EMPTY;
            end
            ST_HALT: begin
                if (!halt) w_state_nxt = ST_EMPTY;
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_EMPTY;
            r_end         <= 1'b0;
            r_rr_ptr      <= '0;
            r_dout        <= '0;
            r_pkt_id      <= '0;
            r_word_id     <= '0;
            r_gen_id      <= '0;
            r_pkt_done    <= 1'b0;
            r_pkt_done_id <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pkt_done <= w_deliver & r_end;
            if (w_deliver && r_end) r_pkt_done_id <= r_pkt_id;
            if (w_deliver) r_rr_ptr <= (w_idx == PW'(NUM_CORES - 1)) ? '0 : w_idx + 1'b1;
            if (gen_rd_en) begin
                r_dout    <= gen_dout;
                r_pkt_id  <= gen_pkt_id;
                r_word_id <= gen_word_id;
                r_gen_id  <= gen_id;
                r_end     <= gen_end;
            end
        end
    end

    assign core_dout    = r_dout;
    assign core_pkt_id  = r_pkt_id;
    assign core_word_id = r_word_id;
    assign core_gen_id  = r_gen_id;
    assign pkt_done     = r_pkt_done;
    assign pkt_done_id  = r_pkt_done_id;
    assign busy         = w_valid;

`ifdef WORD_GEN_DISPATCH_CNT_EN
    logic [31:0] r_cnt [NUM_CORES];

    // Clear on the pkt_done pulse, but a delivery in that same cycle still counts.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CORES; k++) r_cnt[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_CORES; k++) begin
                if (r_pkt_done)         r_cnt[k] <= {31'd0, core_wr_en[k]};
                else if (core_wr_en[k]) r_cnt[k] <= r_cnt[k] + 32'd1;
            end
        end
    end

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_cnt
        assign core_cnt[g*32 +: 32] = r_cnt[g];
    end
`endif

endmodule

// File: doc/word_gen_dispatch.md
Name: word_gen_dispatch

Overview:
- Sits between one word_gen instance and NUM_CORES hash cores.
- Pops generated words from word_gen's FWFT read port, holds each in a 1-entry output register, and hands it to the next non-full core in round-robin order.
- Sustains one word per cycle.
- Signals completion of each word_gen packet to the packet-accounting logic.

Parameters:
- NUM_CORES, 4, number of downstream cores (2..16).
- CHAR_BITS, 7, bits per character (7 or 8).
- WORD_MAX_LEN, 8, max word length in characters.

Ports:
- CLK  in  1  sole clock (word_gen WORD_GEN_CLK domain).
- rst_n  in  1  reset, asynchronous, active-low.
- halt  in  1  stop fetching new words; the held word still drains.
- gen_empty  in  1  word_gen empty.
- gen_rd_en  out  1  word_gen rd_en.
- gen_dout  in  WORD_MAX_LEN*CHAR_BITS  word_gen dout.
- gen_pkt_id  in  16  word_gen pkt_id.
- gen_word_id  in  16  word_gen word_id_out.
- gen_id  in  32  word_gen gen_id.
- gen_end  in  1  word_gen gen_end (last word of packet).
- core_dout  out  WORD_MAX_LEN*CHAR_BITS  registered word, shared by all cores.
- core_pkt_id  out  16  registered pkt_id.
- core_word_id  out  16  registered word_id.
- core_gen_id  out  32  registered gen_id.
- core_wr_en  out  NUM_CORES  one-hot write strobe.
- core_full  in  NUM_CORES  per-core full.
- pkt_done  out  1  one-cycle pulse when a packet's gen_end word has been delivered.
- pkt_done_id  out  16  pkt_id of the completed packet.
- busy  out  1  output register valid.

Behaviour:
- Reset (rst_n low, asynchronous) values:
  - all outputs and registers 0; valid=0; rr_ptr=0.
  - gen_rd_en=0, core_wr_en=0, pkt_done=0, busy=0.
  - Reset mid-transfer discards the held word; no pulse is issued.
- FSM with states ST_EMPTY, ST_LOADED, ST_HALT:
  - ST_EMPTY: if ~halt & ~gen_empty, assert gen_rd_en, capture the word, end flag and ids → ST_LOADED. If halt → ST_HALT.
  - ST_LOADED: the word is offered to the cores. If it is delivered this cycle and ~halt & ~gen_empty, refill in the same cycle (gen_rd_en=1, stay in ST_LOADED). If delivered with no refill → ST_EMPTY (or ST_HALT if halt). If not delivered, hold all registers and keep gen_rd_en=0.
  - ST_HALT: entered only with valid=0. Return to ST_EMPTY when halt=0.
- gen_rd_en is combinational: fetch_ok & ~gen_empty & (~valid | deliver). It is never asserted while gen_empty=1.
- Core selection:
  - sel = first index k, scanning from rr_ptr upward modulo NUM_CORES, with core_full[k]=0.
  - deliver = valid & any(~core_full).
  - core_wr_en[sel] = deliver; it is combinational and drops core_full in the same cycle.
  - After a delivery, rr_ptr = sel+1 mod NUM_CORES. Wrap from NUM_CORES-1 goes to 0.
  - If all cores are full: hold the word, rr_ptr unchanged.
- Latency and throughput:
  - Word popped in cycle t appears on core_* in cycle t+1; earliest delivery is cycle t+1.
  - Throughput is 1 word per cycle while ≥1 core is not full.
- Packet completion:
  - The end flag is captured from gen_end with the word.
  - On delivery of a word with end=1, pkt_done=1 in the next cycle and pkt_done_id = that word's pkt_id.
  - Back-to-back packets may produce pkt_done on consecutive cycles.
- halt:
  - Sampled every cycle; it blocks only the fetch.
  - Asserting halt in the same cycle as a refill suppresses that refill.
  - Asserting halt while holding a word does not invalidate it.
- core_* data registers update only on a fetch; otherwise they hold their value. Cores must qualify them with core_wr_en.

Optional Feature:
- Macro: WORD_GEN_DISPATCH_CNT_EN.
- Defined: adds output core_cnt, NUM_CORES*32 bits.
  - Per-core 32-bit count of delivered words, wrapping at 2^32.
  - Cleared by reset and when pkt_done pulses. A delivery in the pulse cycle counts as 1 after the clear.
- Undefined: port and counters are absent; all other behaviour is identical.

Decomposition:
- Package word_gen_dispatch_pkg:
  - state encodings ST_EMPTY=0, ST_LOADED=1, ST_HALT=2.
  - localparam WORD_BITS = WORD_MAX_LEN*CHAR_BITS.
  - function clog2 for rr_ptr width.
- Sub-module rr_pick, combinational:
  - inputs: req mask (~core_full), rr_ptr.
  - outputs: one-hot grant and its index.
  - Instantiated once.

Test Plan:
- NUM_CORES=4, all cores ready, 8 words with gen_id 0..7 → core_wr_en one-hots in order 0,1,2,3,0,1,2,3, one per cycle; first strobe exactly 1 cycle after the first gen_rd_en.
- core_full=4'b0010, rr_ptr=1, word held → delivered to core 2; rr_ptr becomes 3.
- core_full=4'b1111 for 5 cycles, then 4'b1011 → gen_rd_en=0 and core_dout stable for 5 cycles, then core_wr_en=4'b0100; the next word follows on the next cycle.
- Packet pkt_id=0x1234 whose 3rd word has gen_end=1 → pkt_done=1 for exactly one cycle, 1 cycle after that word's strobe, with pkt_done_id=0x1234.
- halt raised while a word is held and gen_empty=0 → held word delivered, then no gen_rd_en until halt falls; rst_n pulsed low mid-stream → all outputs 0 immediately and rr_ptr=0.
- With WORD_GEN_DISPATCH_CNT_EN: 10 words to 4 ready cores → core_cnt = {2,2,3,3} (cores 3..0); all counts clear on pkt_done.
